// File: rtl/ext_intr_ctrl.sv
// ext_intr_ctrl
// -----------------------------------------------------------------------------
// External-interrupt controller sitting between accelerator / external
// subsystem interrupt sources and the X-HEEP intr_vector_ext_i input.
// Each of NUM_SRC sources has a level/edge mode bit, an enable bit, a pending
// latch and a route field that selects one of NEXT_INT output lines.
// Software programs it through a reg-bus slave port.
//
// Register map (addr[7:0], 32-bit words):
//   0x00 PENDING  R/W1C   0x04 ENABLE  RW   0x08 MODE RW (1 = rising edge)
//   0x0C SET      WO      0x10 STATUS  RO (src_q)
//   0x20+4*i ROUTE[i] RW, bits [RW-1:0]
//
// Ports:
//   clk_i              clock, single domain
//   rst_ni             asynchronous active-low reset
//   reg_req_i [69:0]   packed reg_req_t: {addr[31:0], write, wdata[31:0],
//                      wstrb[3:0], valid} (MSB to LSB)
//   reg_rsp_o [33:0]   packed reg_rsp_t: {rdata[31:0], error, ready}
//   intr_src_i         interrupt sources, active-high, synchronous to clk_i
//   intr_vector_ext_o  registered interrupt lines towards X-HEEP
// -----------------------------------------------------------------------------
module ext_intr_ctrl #(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned NEXT_INT = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [69:0]         reg_req_i,
  output logic [33:0]         reg_rsp_o,
  input  logic [NUM_SRC-1:0]  intr_src_i,
  output logic [NEXT_INT-1:0] intr_vector_ext_o
);

  // Width of one route field; kept at least 1 so a single-line vector still
  // yields a legal field.
  localparam int unsigned RW = (NEXT_INT > 1) ? $clog2(NEXT_INT) : 1;

  localparam logic [7:0] ADDR_PENDING = 8'h00;
  localparam logic [7:0] ADDR_ENABLE  = 8'h04;
  localparam logic [7:0] ADDR_MODE    = 8'h08;
  localparam logic [7:0] ADDR_SET     = 8'h0C;
  localparam logic [7:0] ADDR_STATUS  = 8'h10;
  localparam int unsigned ADDR_ROUTE0 = 32'h20;

  // ---------------------------------------------------------------------------
  // Request unpacking
  // ---------------------------------------------------------------------------
  logic [7:0]  req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_valid;
  logic        unused_req;

  assign req_addr  = reg_req_i[45:38];
  assign req_write = reg_req_i[37];
  assign req_wdata = reg_req_i[36:5];
  assign req_wstrb = reg_req_i[4:1];
  assign req_valid = reg_req_i[0];
  // Only addr[7:0] is decoded and only the low wdata bits are stored.
  assign unused_req = ^{reg_req_i[69:46], req_wdata};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0]  src_q,     src_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  enable_q,  enable_d;
  logic [NUM_SRC-1:0]  mode_q,    mode_d;
  logic [RW-1:0]       route_q [NUM_SRC];
  logic [RW-1:0]       route_d [NUM_SRC];
  logic [NEXT_INT-1:0] intr_q,    intr_d;

  // ---------------------------------------------------------------------------
  // Address decode and bus response
  // ---------------------------------------------------------------------------
  logic               sel_pending, sel_enable, sel_mode, sel_set, sel_status;
  logic [NUM_SRC-1:0] route_sel;
  logic               mapped;
  logic               bad_write;
  logic               rsp_error;
  logic               wr_en;
  logic [31:0]        rsp_rdata;

  always_comb begin
    sel_pending = (req_addr == ADDR_PENDING);
    sel_enable  = (req_addr == ADDR_ENABLE);
    sel_mode    = (req_addr == ADDR_MODE);
    sel_set     = (req_addr == ADDR_SET);
    sel_status  = (req_addr == ADDR_STATUS);
    route_sel   = '0;
    // One-hot ROUTE select: comparing against each slot address avoids an
    // out-of-range array index for addresses past the last source.
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      route_sel[i] = (req_addr == 8'(ADDR_ROUTE0 + 4 * i));
    end
    mapped    = sel_pending | sel_enable | sel_mode | sel_set | sel_status
              | (|route_sel);
    bad_write = req_write && (sel_status || (req_wstrb != 4'hF));
    rsp_error = req_valid && (!mapped || bad_write);
    wr_en     = req_valid && req_write && !rsp_error;
  end

  always_comb begin
    rsp_rdata = '0;
    if (sel_pending) rsp_rdata = 32'(pending_q);
    if (sel_enable)  rsp_rdata = 32'(enable_q);
    if (sel_mode)    rsp_rdata = 32'(mode_q);
    if (sel_status)  rsp_rdata = 32'(src_q);
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (route_sel[i]) rsp_rdata = 32'(route_q[i]);
    end
  end

  assign reg_rsp_o = {rsp_rdata, rsp_error, 1'b1};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] wdata_src;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;

  always_comb begin
    wdata_src = req_wdata[NUM_SRC-1:0];
    src_d     = intr_src_i;

    enable_d = enable_q;
    if (wr_en && sel_enable) enable_d = wdata_src;

    mode_d = mode_q;
    if (wr_en && sel_mode) mode_d = wdata_src;

    set_vec = (intr_src_i & ~src_q) | ((wr_en && sel_set) ? wdata_src : '0);
    clr_vec = (wr_en && sel_pending) ? wdata_src : '0;

    // Edge sources: set beats clear. Level sources load the raw input so
    // that pending_q tracks src_q in the same cycle.
    pending_d = (mode_q & ((pending_q & ~clr_vec) | set_vec))
              | (~mode_q & intr_src_i);

    route_d = route_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (wr_en && route_sel[i]) route_d[i] = req_wdata[RW-1:0];
    end
  end

  // Route values at or above NEXT_INT match no line and are dropped.
  always_comb begin
    intr_d = '0;
    for (int unsigned j = 0; j < NEXT_INT; j++) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (pending_q[i] && enable_q[i] && (32'(route_q[i]) == j)) begin
          intr_d[j] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      intr_q    <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        route_q[i] <= RW'(i % NEXT_INT);
      end
    end else begin
      src_q     <= src_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      intr_q    <= intr_d;
      route_q   <= route_d;
    end
  end

  assign intr_vector_ext_o = intr_q;

endmodule

// File: doc/ext_intr_ctrl.md
# ext_intr_ctrl

Parametrised external-interrupt controller between the accelerator/external-subsystem interrupt sources and the X-HEEP `intr_vector_ext_i` input. It replaces the fixed one-source-to-line-0 wiring with `NUM_SRC` sources, each with a software-selectable level/edge mode, enable, pending latch and routing to any of the `NEXT_INT` external interrupt lines. Software accesses its registers as an external peripheral slave on the reg bus.

## Interface
- `NUM_SRC`, default 4: number of interrupt sources, 1..24.
- `NEXT_INT`, default 16: width of the external interrupt vector; must equal `core_v_mini_mcu_pkg::NEXT_INT`.
- `RW`, derived: `$clog2(NEXT_INT)`, width of a route field.

Ports:
- `clk_i`, in, 1: clock; single clock domain.
- `rst_ni`, in, 1: reset; asynchronous, active-low.
- `reg_req_i`, in, `reg_req_t`: register bus request (valid, write, addr, wdata, wstrb).
- `reg_rsp_o`, out, `reg_rsp_t`: register bus response (rdata, error, ready).
- `intr_src_i`, in, `NUM_SRC`: interrupt sources, synchronous to `clk_i`, active-high.
- `intr_vector_ext_o`, out, `NEXT_INT`: registered interrupt lines to X-HEEP.

## Operation
- Register map, decoded on `addr[7:0]`, 32-bit words:
  - 0x00 PENDING, R/W1C.
  - 0x04 ENABLE, RW.
  - 0x08 MODE, RW; 1 = rising edge, 0 = level.
  - 0x0C SET, WO; a write of 1 sets PENDING for edge-mode sources; reads 0.
  - 0x10 STATUS, RO; the `src_q` sample of each source.
  - 0x20+4*i ROUTE[i], RW, bits [RW-1:0]; selects the output line for source i.
- Bits at or above `NUM_SRC`, and route bits at or above `RW`, read as 0 and ignore writes.
- Reset values:
  - PENDING = 0, ENABLE = 0, MODE = 0, `src_q` = 0.
  - ROUTE[i] = i mod `NEXT_INT`.
  - `intr_vector_ext_o` = 0; `reg_rsp_o` = '0 apart from the combinational response below.
- Bus response:
  - `ready` = 1 combinationally.
  - `rdata` is combinational from current register state.
  - `error` = 1 for an unmapped address, for a write to STATUS, or for a write with `wstrb` != 4'hF. Such writes have no effect.
- Edge mode:
  - PENDING[i] sets when `intr_src_i[i]` & ~`src_q[i]`, or on a SET write with bit i = 1.
  - PENDING[i] clears on a PENDING write with bit i = 1.
  - If set and clear occur in the same cycle, set wins.
- Level mode: PENDING[i] equals `src_q[i]` every cycle. W1C and SET have no effect on it.
- MODE change edge→level: PENDING takes the level value on the next edge. Level→edge: PENDING keeps its current value and is then latched.
- Output: `intr_vector_ext_o[j]` is the registered OR over i of (PENDING[i] & ENABLE[i] & ROUTE[i]==j). Several sources may share a line. A route value ≥ `NEXT_INT` selects no line.
- The ENABLE mask is applied only at the output; disabled sources still latch PENDING.

## Timing
- `src_q` registers `intr_src_i` on every edge.
- Edge source rising in cycle n: PENDING visible from cycle n+1, `intr_vector_ext_o` high from cycle n+2.
- Level source: `intr_vector_ext_o` follows `intr_src_i` with 2-cycle latency on both assertion and deassertion.
- Register writes take effect at the clock edge that completes the access; they are visible to reads and the output path in the next cycle. A W1C write in cycle n drops the output in cycle n+2 unless the source re-fires.
- A source already high when reset releases produces one edge event, because `src_q` resets to 0.
- Reset asserted mid-operation clears all state and outputs asynchronously. No interrupt is retained.

## Test plan
- Reset, then read 0x00/0x04/0x08 = 0 and ROUTE[1] = 1; `intr_vector_ext_o` = 0.
- Edge path: MODE=0x1, ENABLE=0x1, 1-cycle pulse on src 0 → `intr_vector_ext_o` = 0x0001 two cycles later and held. Write PENDING=0x1 → output 0 two cycles later.
- Level path: MODE=0, ENABLE=0x2, hold src 1 high 5 cycles → line 1 high for exactly 5 cycles, lagging by 2. W1C of bit 1 during the pulse has no effect.
- Routing/sharing: ROUTE[0]=7, ROUTE[2]=7, both edge and enabled; pulse src 2 only → output 0x0080. Clear bit 2 while src 0 pending → 0x0080 stays.
- Set-vs-clear collision: src 0 rises in the same cycle as a PENDING=0x1 write → PENDING[0] = 1 afterwards. SET=0x1 in edge mode → pending without a source edge.
- Errors and reset: write 0x14 → `error`=1, no state change; `wstrb`=4'h1 to ENABLE → `error`=1, ENABLE unchanged. Assert `rst_ni` with interrupts pending → output 0 immediately, registers at reset values.
